// File: rtl/line_layer_select.sv
// Registered display-line selector: NLAYER prioritised layers, default and idle lines.
// Define LINE_LAYER_SELECT_TRANSITION_BLANK_EN to blank BLANK_FRAMES frames on scene change.
module line_layer_select #(
    parameter int LINE_W       = 480,
    parameter int NLAYER       = 4,
    parameter int ADDR_W       = 10,
    parameter int WIN_LO       = 45,
    parameter int WIN_HI       = 595,
    parameter int BLANK_FRAMES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             h_addr,
    input  logic [ADDR_W-1:0]             v_addr,
    input  logic                          frame_start,
    input  logic                          active,
    input  logic [NLAYER-1:0]             layer_show,
    input  logic [NLAYER-1:0]             layer_windowed,
    input  logic [NLAYER*LINE_W-1:0]      layer_data,
    input  logic [LINE_W-1:0]             default_data,
    input  logic [LINE_W-1:0]             idle_data,
    output logic [LINE_W-1:0]             DisLine,
    output logic [$clog2(NLAYER+2)-1:0]   sel_code,
    output logic                          blanking
);

    localparam int SEL_W = $clog2(NLAYER + 2);
    localparam logic [SEL_W-1:0]  SEL_DEF  = SEL_W'(NLAYER);
    localparam logic [SEL_W-1:0]  SEL_IDLE = SEL_W'(NLAYER + 1);
    localparam logic [ADDR_W-1:0] WIN_LO_A = ADDR_W'(WIN_LO);
    localparam logic [ADDR_W-1:0] WIN_HI_A = ADDR_W'(WIN_HI);

    logic                r_act_q;
    logic [NLAYER-1:0]   r_show_q;
    logic [LINE_W-1:0]   r_line;
    logic [SEL_W-1:0]    r_sel;
    logic                r_blanking;

    logic                w_in_win;
    logic [NLAYER-1:0]   w_qual;
    logic                w_scene_chg;
    logic                w_blank_now;
    logic [SEL_W-1:0]    w_sel_code;
    logic [LINE_W-1:0]   w_sel_line;
    logic                w_unused;

    // v_addr is carried on the port for the renderer but plays no part here
    assign w_unused = ^v_addr;

    assign w_in_win    = (h_addr >= WIN_LO_A) && (h_addr <= WIN_HI_A);
    assign w_qual      = r_show_q & (~layer_windowed | {NLAYER{w_in_win}});
    assign w_scene_chg = frame_start &&
                         ({active, layer_show} != {r_act_q, r_show_q});

    // Walk from lowest priority upward so the lowest qualifying index wins
    always_comb begin
        w_sel_code = SEL_DEF;
        w_sel_line = default_data;
        for (int i = NLAYER - 1; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_sel_code = SEL_W'(i);
                w_sel_line = layer_data[i*LINE_W +: LINE_W];
            end
        end
        if (!r_act_q) begin
            w_sel_code = SEL_IDLE;
            w_sel_line = idle_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_q  <= 1'b0;
            r_show_q <= '0;
        end else if (frame_start) begin
            r_act_q  <= active;
            r_show_q <= layer_show;
        end
    end

`ifdef LINE_LAYER_SELECT_TRANSITION_BLANK_EN
    localparam int CNT_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [0:0] S_SHOW  = 1'b0;
    localparam logic [0:0] S_BLANK = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_blank_cnt;

    // A scene change reloads the count even on the frame that would end the blank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_SHOW;
            r_blank_cnt <= '0;
        end else if (w_scene_chg && (BLANK_FRAMES > 0)) begin
            r_state     <= S_BLANK;
            r_blank_cnt <= CNT_W'(BLANK_FRAMES);
        end else if (frame_start && (r_state == S_BLANK)) begin
            if (r_blank_cnt == CNT_W'(1)) begin
                r_state     <= S_SHOW;
                r_blank_cnt <= '0;
            end else begin
                r_blank_cnt <= r_blank_cnt - CNT_W'(1);
            end
        end
    end

    assign w_blank_now = (r_state == S_BLANK);
    assign blanking    = r_blanking;
`else
    assign w_blank_now = 1'b0;
    assign blanking    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line     <= '0;
            r_sel      <= SEL_IDLE;
            r_blanking <= 1'b0;
        end else begin
            r_line     <= w_blank_now ? '0 : w_sel_line;
            r_sel      <= w_sel_code;
            r_blanking <= w_blank_now;
        end
    end

    assign DisLine  = r_line;
    assign sel_code = r_sel;

endmodule

// File: doc/line_layer_select.md
Name: line_layer_select

Overview:
- Parametrised, registered successor to the display-line selector.
- Picks one LINE_W-bit display line from NLAYER prioritised layers, a default line or an idle line, and drives the renderer's DisLine input.
- Layer visibility is sampled only at frame boundaries, so there is no mid-frame tearing. Per-layer horizontal windowing is evaluated every pixel.
- An optional blank interval is inserted whenever the visible scene changes.

Parameters:
- LINE_W, 480, width of one display line.
- NLAYER, 4, number of prioritised layers; index 0 has the highest priority.
- ADDR_W, 10, width of h_addr and v_addr.
- WIN_LO, 45, first h_addr (inclusive) at which windowed layers are visible.
- WIN_HI, 595, last h_addr (inclusive) at which windowed layers are visible.
- BLANK_FRAMES, 2, number of whole frames output as blank after a scene change; 0 means no blank.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- h_addr  in  ADDR_W  current horizontal pixel address.
- v_addr  in  ADDR_W  current vertical address; pass-through only, no function in this block.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- active  in  1  game running; 0 selects idle_data.
- layer_show  in  NLAYER  per-layer request to be shown.
- layer_windowed  in  NLAYER  1 = layer visible only inside [WIN_LO, WIN_HI]; static configuration.
- layer_data  in  NLAYER*LINE_W  layer i occupies bits [i*LINE_W +: LINE_W].
- default_data  in  LINE_W  line shown when no layer qualifies.
- idle_data  in  LINE_W  line shown while not active (start screen).
- DisLine  out  LINE_W  selected line, registered.
- sel_code  out  clog2(NLAYER+2)  current source: 0..NLAYER-1 = layer, NLAYER = default, NLAYER+1 = idle.
- blanking  out  1  high while a blank interval is in progress.

Behaviour:
- Reset (async): DisLine=0, sel_code=NLAYER+1, blanking=0, act_q=0, show_q=0, state=SHOW, blank_cnt=0.
- Frame latch: on a cycle with frame_start=1, act_q<=active and show_q<=layer_show. These are held until the next frame_start.
- Scene change: at frame_start, the new {active, layer_show} differs from {act_q, show_q}.
- Per-cycle source choice, using the latched values:
  - act_q=0 -> idle.
  - Otherwise, the lowest i with show_q[i]=1 and (layer_windowed[i]=0 or WIN_LO<=h_addr<=WIN_HI).
  - Otherwise -> default.
- Outside the window, a windowed layer falls through to the next priority for that pixel only.
- Latency: DisLine and sel_code are registered. They reflect h_addr and the latched state one clock later.
- State machine (TRANSITION_BLANK_EN defined):
  - SHOW: on a scene change with BLANK_FRAMES>0 -> BLANK, blank_cnt<=BLANK_FRAMES.
  - BLANK:
    - DisLine<=0 and blanking=1; sel_code keeps tracking the selection.
    - Each frame_start without a scene change decrements blank_cnt.
    - If blank_cnt=1 at a frame_start -> SHOW; the new scene appears the cycle after that pulse.
    - A scene change during BLANK reloads blank_cnt<=BLANK_FRAMES and stays in BLANK.
- Boundaries:
  - frame_start coinciding with the last blank frame and a scene change: the reload wins.
  - h_addr == WIN_LO or h_addr == WIN_HI counts as inside the window.
  - Multiple layer_show bits set: strict priority, index 0 first.
  - Reset asserted mid-blank: immediate return to the reset values.
  - Before the first frame_start after reset, the output is idle_data, starting from the second clock after reset release.
- layer_show and active changes between frame_start pulses have no effect until the next pulse.

Optional Feature:
- Macro: LINE_LAYER_SELECT_TRANSITION_BLANK_EN.
- Defined: BLANK state, blank_cnt and the blanking output behave as above.
- Undefined: no BLANK state and blanking is tied to 0. A scene change takes effect the cycle after its frame_start. BLANK_FRAMES is ignored.

Test Plan:
- Reset release, no frame_start, idle_data=0xA5.. -> DisLine=0 during reset, then idle_data from the second clk; sel_code=5 (NLAYER=4).
- frame_start with active=1, layer_show=4'b0000 -> DisLine=default_data one cycle later; sel_code=4; with the macro, blanking=1 and DisLine=0 for 2 frames first.
- active=1, show=4'b0011, layer_windowed=4'b0001, sweep h_addr 44,45,595,596 -> sel_code 1,0,0,1.
- layer_show changes mid-frame from 4'b0100 to 4'b0010 -> DisLine unchanged until the next frame_start, then layer 1 is selected (after blank if enabled).
- Macro on, BLANK_FRAMES=2, a second scene change at the first frame_start inside blank -> blanking stays high for 2 further frames counted from that pulse.
- rst pulsed mid-BLANK -> blanking=0 and DisLine=0 immediately (async), then idle_data.
